// File: rtl/mt9p031_pkg.sv
// Shared definitions for the MT9P031 timing sequencer.
//   DEF_CNT_WIDTH : default width of size/blanking/coordinate counters
//   state_e       : sequencer state encoding
//   clamp1        : maps 0 to 1, leaves any other value unchanged
package mt9p031_pkg;

    localparam int unsigned DEF_CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FRONT  = 3'd1,
        S_LINE   = 3'd2,
        S_HBLANK = 3'd3,
        S_BACK   = 3'd4,
        S_VBLANK = 3'd5
    } state_e;

    // Callers cast to their own counter width (CNT_WIDTH <= 32).
    function automatic logic [31:0] clamp1(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/mt9p031_timing_ctrl_if.sv
// Configuration and video-timing bundle of the MT9P031 timing sequencer.
//   master : bfm side, drives the i_* configuration, observes the o_* timing
//   slave  : sequencer side, consumes i_*, drives o_*
interface mt9p031_timing_ctrl_if #(
    parameter int unsigned CNT_WIDTH = mt9p031_pkg::DEF_CNT_WIDTH
);
    logic                 i_enable;
    logic                 i_pause;
    logic                 i_continue_lval;
    logic [CNT_WIDTH-1:0] i_width;
    logic [CNT_WIDTH-1:0] i_height;
    logic [CNT_WIDTH-1:0] i_h_blank;
    logic [CNT_WIDTH-1:0] i_v_blank;
    logic [CNT_WIDTH-1:0] i_fval_lval_gap;
    logic                 o_fval;
    logic                 o_lval;
    logic [CNT_WIDTH-1:0] o_x_cnt;
    logic [CNT_WIDTH-1:0] o_y_cnt;
    logic                 o_frame_start;
    logic                 o_frame_done;

    modport master (
        output i_enable, i_pause, i_continue_lval, i_width, i_height,
               i_h_blank, i_v_blank, i_fval_lval_gap,
        input  o_fval, o_lval, o_x_cnt, o_y_cnt, o_frame_start, o_frame_done
    );

    modport slave (
        input  i_enable, i_pause, i_continue_lval, i_width, i_height,
               i_h_blank, i_v_blank, i_fval_lval_gap,
        output o_fval, o_lval, o_x_cnt, o_y_cnt, o_frame_start, o_frame_done
    );
endinterface

// File: rtl/mt9p031_shadow_regs.sv
// Frame-start snapshot of the sequencer configuration.
//   clk_pix, reset : pixel clock, synchronous active-high reset
//   load           : 1 on the IDLE->FRONT transition; captures the req_* values
//   req_*          : live configuration inputs
//   width, height, h_blank, gap : captured values, 0 replaced by 1
//   v_blank        : captured value, 0 kept (no v-blank)
//   continue_lval  : captured continuous-lval mode
module mt9p031_shadow_regs
    import mt9p031_pkg::*;
#(
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int unsigned FVAL_LVAL_GAP   = 3,
    parameter string       FVAL_LVAL_ALIGN = "FALSE"
) (
    input  logic                 clk_pix,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 req_continue_lval,
    input  logic [CNT_WIDTH-1:0] req_width,
    input  logic [CNT_WIDTH-1:0] req_height,
    input  logic [CNT_WIDTH-1:0] req_h_blank,
    input  logic [CNT_WIDTH-1:0] req_v_blank,
    input  logic [CNT_WIDTH-1:0] req_gap,
    output logic                 continue_lval,
    output logic [CNT_WIDTH-1:0] width,
    output logic [CNT_WIDTH-1:0] height,
    output logic [CNT_WIDTH-1:0] h_blank,
    output logic [CNT_WIDTH-1:0] v_blank,
    output logic [CNT_WIDTH-1:0] gap
);

    localparam int unsigned FIXED_GAP = (FVAL_LVAL_GAP == 0) ? 1 : FVAL_LVAL_GAP;
    localparam bit          ALIGN     = (FVAL_LVAL_ALIGN == "TRUE");

    logic [CNT_WIDTH-1:0] gap_next;

    assign gap_next = ALIGN ? CNT_WIDTH'(FIXED_GAP) : CNT_WIDTH'(clamp1(32'(req_gap)));

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            continue_lval <= 1'b0;
            width         <= '0;
            height        <= '0;
            h_blank       <= '0;
            v_blank       <= '0;
            gap           <= '0;
        end else if (load) begin
            continue_lval <= req_continue_lval;
            width         <= CNT_WIDTH'(clamp1(32'(req_width)));
            height        <= CNT_WIDTH'(clamp1(32'(req_height)));
            h_blank       <= CNT_WIDTH'(clamp1(32'(req_h_blank)));
            v_blank       <= req_v_blank;
            gap           <= gap_next;
        end
    end

endmodule

// File: rtl/mt9p031_timing_ctrl.sv
// Frame/line timing sequencer for the MT9P031 sensor model.
//   clk_pix : pixel clock
//   reset   : synchronous active-high reset
//   bus     : slave side of mt9p031_timing_ctrl_if; i_* window/blanking/control settings in,
//             registered fval/lval, x/y coordinates and frame start/done pulses out
module mt9p031_timing_ctrl
    import mt9p031_pkg::*;
#(
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int unsigned FVAL_LVAL_GAP   = 3,
    parameter string       FVAL_LVAL_ALIGN = "FALSE"
) (
    input logic                  clk_pix,
    input logic                  reset,
    mt9p031_timing_ctrl_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] x_q, x_d;
    logic [CNT_WIDTH-1:0] y_q, y_d;
    logic                 fval_q, fval_d;
    logic                 lval_q, lval_d;
    logic                 fs_q, fs_d;
    logic                 fd_q, fd_d;

    logic                 start;
    logic                 continue_lval;
    logic [CNT_WIDTH-1:0] width, height, h_blank, v_blank, gap;

    // enable/pause only matter while idle; mid-frame changes are ignored
    assign start = (state_q == S_IDLE) && bus.i_enable && !bus.i_pause;

    mt9p031_shadow_regs #(
        .CNT_WIDTH       (CNT_WIDTH),
        .FVAL_LVAL_GAP   (FVAL_LVAL_GAP),
        .FVAL_LVAL_ALIGN (FVAL_LVAL_ALIGN)
    ) u_shadow (
        .clk_pix           (clk_pix),
        .reset             (reset),
        .load              (start),
        .req_continue_lval (bus.i_continue_lval),
        .req_width         (bus.i_width),
        .req_height        (bus.i_height),
        .req_h_blank       (bus.i_h_blank),
        .req_v_blank       (bus.i_v_blank),
        .req_gap           (bus.i_fval_lval_gap),
        .continue_lval     (continue_lval),
        .width             (width),
        .height            (height),
        .h_blank           (h_blank),
        .v_blank           (v_blank),
        .gap               (gap)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        fval_d  = fval_q;
        lval_d  = lval_q;
        fs_d    = 1'b0;
        fd_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FRONT;
                    fval_d  = 1'b1;
                    fs_d    = 1'b1;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_FRONT: begin
                if (cnt_q == gap - CNT_ONE) begin
                    state_d = S_LINE;
                    lval_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_LINE: begin
                if (x_q != width - CNT_ONE) begin
                    x_d = x_q + CNT_ONE;
                end else if (y_q == height - CNT_ONE) begin
                    state_d = S_BACK;
                    lval_d  = 1'b0;
                    cnt_d   = '0;
                end else if (continue_lval) begin
                    // lval stays high; only the coordinates move to the next line
                    x_d = '0;
                    y_d = y_q + CNT_ONE;
                end else begin
                    state_d = S_HBLANK;
                    lval_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_HBLANK: begin
                if (cnt_q == h_blank - CNT_ONE) begin
                    state_d = S_LINE;
                    lval_d  = 1'b1;
                    x_d     = '0;
                    y_d     = y_q + CNT_ONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_BACK: begin
                if (cnt_q == gap - CNT_ONE) begin
                    fval_d  = 1'b0;
                    fd_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = (v_blank == '0) ? S_IDLE : S_VBLANK;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_VBLANK: begin
                if (cnt_q == v_blank - CNT_ONE) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                fval_d  = 1'b0;
                lval_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            fval_q  <= 1'b0;
            lval_q  <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fval_q  <= fval_d;
            lval_q  <= lval_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
        end
    end

    assign bus.o_fval        = fval_q;
    assign bus.o_lval        = lval_q;
    assign bus.o_x_cnt       = x_q;
    assign bus.o_y_cnt       = y_q;
    assign bus.o_frame_start = fs_q;
    assign bus.o_frame_done  = fd_q;

endmodule

// File: tb/tb_mt9p031_timing_ctrl.sv
// Self-checking bench for mt9p031_timing_ctrl. Expected timing comes from a per-cycle
// arithmetic model of a frame (offset from frame start -> fval/lval/x/y/pulses).
module tb_mt9p031_timing_ctrl;

    typedef struct {
        int w;
        int h;
        int hb;
        int vb;
        int g;
        bit cont;
    } cfg_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    mt9p031_timing_ctrl_if #(.CNT_WIDTH(16)) bus ();

    mt9p031_timing_ctrl #(
        .CNT_WIDTH       (16),
        .FVAL_LVAL_GAP   (3),
        .FVAL_LVAL_ALIGN ("FALSE")
    ) dut (
        .clk_pix (clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int cl(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int frame_len(input cfg_t c);
        return 2 * c.g + c.w * c.h + (c.cont ? 0 : (c.h - 1) * c.hb);
    endfunction

    // {fval, lval, frame_start, frame_done, x[15:0], y[15:0]} at offset k from frame start
    function automatic logic [35:0] model(input cfg_t c, input int k, input int len);
        logic fv, lv, fs, fd;
        int   x, y, p, per;
        fv = (k < len);
        fs = (k == 0);
        fd = (k == len);
        lv = 1'b0;
        x  = 0;
        y  = 0;
        p  = k - c.g;
        per = c.cont ? c.w : c.w + c.hb;
        if (k < len && p >= 0 && p / per < c.h && p % per < c.w) begin
            lv = 1'b1;
            x  = p % per;
            y  = p / per;
        end
        return {fv, lv, fs, fd, 16'(x), 16'(y)};
    endfunction

    function automatic logic [35:0] observed(input logic use_xy);
        return {bus.o_fval, bus.o_lval, bus.o_frame_start, bus.o_frame_done,
                use_xy ? bus.o_x_cnt : 16'h0, use_xy ? bus.o_y_cnt : 16'h0};
    endfunction

    task automatic compare(input string tag, input int k, input logic [35:0] obs,
                           input logic [35:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic apply(input int w, input int h, input int hb, input int vb, input int g,
                         input bit cont, output cfg_t c);
        bus.i_width         = 16'(w);
        bus.i_height        = 16'(h);
        bus.i_h_blank       = 16'(hb);
        bus.i_v_blank       = 16'(vb);
        bus.i_fval_lval_gap = 16'(g);
        bus.i_continue_lval = cont;
        c.w    = cl(w);
        c.h    = cl(h);
        c.hb   = cl(hb);
        c.vb   = vb;
        c.g    = cl(g);
        c.cont = cont;
    endtask

    // Idle stretch: fval low, no pulses, for n cycles; ends on the next negedge.
    task automatic check_idle(input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            compare(tag, i, observed(1'b0), 36'h0);
        end
        @(negedge clk);
    endtask

    task automatic wait_for_start(input int limit, input string tag);
        int n;
        n = 0;
        while (bus.o_frame_start !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        compare(tag, n, {35'h0, bus.o_frame_start}, 36'h1);
    endtask

    // Called on the negedge of the frame_start cycle; returns on the frame_done cycle.
    // poke_kind: 1 raise pause, 2 set width 8, 3 assert reset, 4 drop enable.
    task automatic check_frame(input cfg_t c, input int poke_k, input int poke_kind,
                               input string tag);
        int          len;
        bit          aborted;
        logic [35:0] exp;
        len     = frame_len(c);
        aborted = 1'b0;
        for (int k = 0; k <= len; k++) begin
            if (k > 0) @(negedge clk);
            exp = model(c, k, len);
            compare(tag, k, observed(exp[34]), exp);
            if (k == poke_k) begin
                case (poke_kind)
                    1: bus.i_pause = 1'b1;
                    2: bus.i_width = 16'd8;
                    3: begin reset = 1'b1; aborted = 1'b1; end
                    4: bus.i_enable = 1'b0;
                    default: ;
                endcase
            end
            if (aborted) break;
        end
        if (aborted) begin
            for (int i = 1; i <= 4; i++) begin
                @(negedge clk);
                compare({tag, "_reset"}, i, observed(1'b1), 36'h0);
            end
            reset = 1'b0;
        end
    endtask

    initial begin
        cfg_t c;
        int   prev_vb;
        bus.i_enable = 1'b0;
        bus.i_pause  = 1'b0;
        apply(16, 16, 4, 10, 3, 1'b0, c);

        // Reset state
        repeat (20) @(negedge clk);
        compare("reset_state", 0, observed(1'b1), 36'h0);
        reset        = 1'b0;
        bus.i_enable = 1'b1;
        wait_for_start(10, "first_start");
        check_frame(c, -1, 0, "frame16");

        // Continuous lval
        apply(16, 16, 4, 10, 3, 1'b1, c);
        check_idle(10, "vblank1");
        check_frame(c, -1, 0, "cont16");

        // Pause mid-frame: frame completes, no next start until pause drops
        apply(16, 16, 4, 10, 3, 1'b0, c);
        check_idle(10, "vblank2");
        check_frame(c, 100, 1, "pause_frame");
        check_idle(29, "paused_idle");
        bus.i_pause = 1'b0;
        @(negedge clk);
        // Width change mid-frame only takes effect on the next frame
        check_frame(c, 50, 2, "resume_frame");
        c.w = 8;
        check_idle(10, "vblank3");
        check_frame(c, -1, 0, "w8_frame");

        // Reset during LINE
        check_idle(10, "vblank4");
        check_frame(c, c.g + 5, 3, "reset_mid");
        wait_for_start(10, "restart");
        check_frame(c, -1, 0, "after_reset");

        // All-zero settings clamp to a 3-clock frame with a single idle clock between frames
        apply(0, 0, 0, 0, 0, 1'b0, c);
        check_idle(10, "vblank5");
        for (int i = 0; i < 3; i++) begin
            check_frame(c, -1, 0, "zero_cfg");
            check_idle(0, "zero_gap");
        end
        prev_vb = 0;
        check_frame(c, -1, 0, "zero_cfg");

        // Randomized settings
        for (int i = 0; i < 16; i++) begin
            apply($urandom_range(12, 0), $urandom_range(6, 0), $urandom_range(5, 0),
                  $urandom_range(6, 0), $urandom_range(4, 0), 1'($urandom_range(1, 0)), c);
            check_idle(prev_vb, "rand_gap");
            prev_vb = c.vb;
            check_frame(c, (i == 15) ? 1 : -1, (i == 15) ? 4 : 0, "rand_frame");
        end

        // Enable dropped during the last frame: stays idle until re-enabled
        check_idle(prev_vb + 6, "disabled_idle");
        bus.i_enable = 1'b1;
        @(negedge clk);
        check_frame(c, -1, 0, "reenable_frame");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
